glb_host_xfer: RTL and testbench

Host-side transfer engine for a single PE cluster slice. Streams weights and activations from a host input stream into the global buffer (GLB) write ports and pulses the cluster start. After the cluster reports compute completion, it reads the final partial sums back out of the GLB psum bank and emits them on a back-pressured output stream. It is the opposite end of the GLB host ports: it writes what the router reads, and it reads what the router writes.

---
 rtl/glb_host_xfer.sv | 185 ++++++++++++++++++
 tb/tb_glb_host_xfer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_host_xfer.sv
// Host-side transfer engine: streams weights/activations into the GLB write
// ports, kicks the cluster, then drains psums out through a 2-entry FIFO.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for cmd_go
// LOAD_W    | accepting NUM_WGHT weight beats, writing the GLB weight port
// LOAD_A    | accepting NUM_IACT activation beats, writing the GLB iact port
// START     | one-cycle cluster start pulse
// WAIT_COMP | waiting for compute_done
// DRAIN     | reading psums from the GLB and streaming them out
// FINISH    | one-cycle job_done pulse
module glb_host_xfer #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10,
  parameter int NUM_WGHT      = 9,
  parameter int NUM_IACT      = 25,
  parameter int NUM_PSUM      = 9,
  parameter int WGHT_BASE     = 0,
  parameter int IACT_BASE     = 100,
  parameter int PSUM_BASE     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_go,
  output logic                     busy,
  output logic                     job_done,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_BITWIDTH-1:0] s_data,
  output logic                     write_en_wght,
  output logic [ADDR_BITWIDTH-1:0] w_addr_wght,
  output logic [DATA_BITWIDTH-1:0] w_data_wght,
  output logic                     write_en_iact,
  output logic [ADDR_BITWIDTH-1:0] w_addr_iact,
  output logic [DATA_BITWIDTH-1:0] w_data_iact,
  output logic                     start,
  input  logic                     compute_done,
  output logic                     read_req_psum,
  output logic [ADDR_BITWIDTH-1:0] r_addr_psum,
  input  logic [DATA_BITWIDTH-1:0] r_data_psum,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_BITWIDTH-1:0] m_data,
  output logic                     m_last
);

  localparam int CNT_MAX_AP = (NUM_IACT > NUM_PSUM) ? NUM_IACT : NUM_PSUM;
  localparam int CNT_MAX    = (CNT_MAX_AP > NUM_WGHT) ? CNT_MAX_AP : NUM_WGHT;
  localparam int CW         = $clog2(CNT_MAX + 1);

  localparam logic [ADDR_BITWIDTH-1:0] W_BASE = ADDR_BITWIDTH'(WGHT_BASE);
  localparam logic [ADDR_BITWIDTH-1:0] A_BASE = ADDR_BITWIDTH'(IACT_BASE);
  localparam logic [ADDR_BITWIDTH-1:0] P_BASE = ADDR_BITWIDTH'(PSUM_BASE);

  typedef enum logic [2:0] {
    IDLE, LOAD_W, LOAD_A, START, WAIT_COMP, DRAIN, FINISH
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]            ld_cnt;
  logic [CW-1:0]            rd_cnt;
  logic [CW-1:0]            out_cnt;
  logic [DATA_BITWIDTH-1:0] fifo_mem [2];
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [1:0]               fifo_cnt;
  logic                     pend_q;
  logic                     beat;
  logic                     pop;
  logic                     issue;
  logic [2:0]               occ_nx;

  assign s_ready = (state == LOAD_W) || (state == LOAD_A);
  assign beat    = s_valid && s_ready;
  assign m_valid = (fifo_cnt != 2'd0);
  assign m_data  = m_valid ? fifo_mem[rd_ptr] : '0;
  assign m_last  = m_valid && (out_cnt == CW'(NUM_PSUM - 1));
  assign pop     = m_valid && m_ready;

  // Entries held after this edge plus the read still in the GLB pipe; a new
  // read is only issued when its data is guaranteed a free FIFO slot.
  assign occ_nx = {1'b0, fifo_cnt} + {2'b0, pend_q} + {2'b0, read_req_psum} - {2'b0, pop};
  assign issue  = (state_nx == DRAIN) && (rd_cnt < CW'(NUM_PSUM)) && (occ_nx < 3'd2);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (cmd_go) state_nx = LOAD_W;
      LOAD_W:    if (beat && (ld_cnt == CW'(NUM_WGHT - 1))) state_nx = LOAD_A;
      LOAD_A:    if (beat && (ld_cnt == CW'(NUM_IACT - 1))) state_nx = START;
      START:     state_nx = WAIT_COMP;
      WAIT_COMP: if (compute_done) state_nx = DRAIN;
      DRAIN:     if (pop && m_last) state_nx = FINISH;
      FINISH:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Registered status strobes, decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy     <= 1'b0;
      job_done <= 1'b0;
      start    <= 1'b0;
    end else begin
      busy     <= (state_nx != IDLE);
      job_done <= (state_nx == FINISH);
      start    <= (state_nx == START);
    end
  end

  // Load path: each accepted beat becomes one GLB write on the next cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ld_cnt        <= '0;
      write_en_wght <= 1'b0;
      w_addr_wght   <= '0;
      w_data_wght   <= '0;
      write_en_iact <= 1'b0;
      w_addr_iact   <= '0;
      w_data_iact   <= '0;
    end else begin
      write_en_wght <= beat && (state == LOAD_W);
      write_en_iact <= beat && (state == LOAD_A);
      if ((state == IDLE) && cmd_go) begin
        ld_cnt <= '0;
      end else if (beat) begin
        if (state == LOAD_W) begin
          w_addr_wght <= W_BASE + ADDR_BITWIDTH'(ld_cnt);
          w_data_wght <= s_data;
          ld_cnt      <= (ld_cnt == CW'(NUM_WGHT - 1)) ? '0 : ld_cnt + 1'b1;
        end else begin
          w_addr_iact <= A_BASE + ADDR_BITWIDTH'(ld_cnt);
          w_data_iact <= s_data;
          ld_cnt      <= (ld_cnt == CW'(NUM_IACT - 1)) ? '0 : ld_cnt + 1'b1;
        end
      end
    end
  end

  // Drain path: psum read issue, one-cycle return tracking and output FIFO.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_cnt        <= '0;
      out_cnt       <= '0;
      read_req_psum <= 1'b0;
      r_addr_psum   <= '0;
      pend_q        <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      fifo_cnt      <= 2'd0;
      fifo_mem[0]   <= '0;
      fifo_mem[1]   <= '0;
    end else begin
      read_req_psum <= issue;
      pend_q        <= read_req_psum;
      if ((state == IDLE) && cmd_go) begin
        rd_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (issue) begin
          r_addr_psum <= P_BASE + ADDR_BITWIDTH'(rd_cnt);
          rd_cnt      <= rd_cnt + 1'b1;
        end
        if (pop) out_cnt <= out_cnt + 1'b1;
      end
      if (pend_q) begin
        fifo_mem[wr_ptr] <= r_data_psum;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, pend_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_glb_host_xfer.sv
// Randomized job-level bench for glb_host_xfer with a GLB psum memory model.
module tb_glb_host_xfer;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int NW = 9;
  localparam int NA = 25;
  localparam int NP = 9;
  localparam int NL = NW + NA;
  localparam int WB = 0;
  localparam int IB = 1020;
  localparam int PB = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_go;
  logic          busy;
  logic          job_done;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          write_en_wght;
  logic [AW-1:0] w_addr_wght;
  logic [DW-1:0] w_data_wght;
  logic          write_en_iact;
  logic [AW-1:0] w_addr_iact;
  logic [DW-1:0] w_data_iact;
  logic          start;
  logic          compute_done;
  logic          read_req_psum;
  logic [AW-1:0] r_addr_psum;
  logic [DW-1:0] r_data_psum;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  always #5 clk = ~clk;

  glb_host_xfer #(
    .DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .NUM_WGHT(NW), .NUM_IACT(NA),
    .NUM_PSUM(NP), .WGHT_BASE(WB), .IACT_BASE(IB), .PSUM_BASE(PB)
  ) dut (
    .clk(clk), .reset(reset), .cmd_go(cmd_go), .busy(busy), .job_done(job_done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .write_en_wght(write_en_wght), .w_addr_wght(w_addr_wght), .w_data_wght(w_data_wght),
    .write_en_iact(write_en_iact), .w_addr_iact(w_addr_iact), .w_data_iact(w_data_iact),
    .start(start), .compute_done(compute_done),
    .read_req_psum(read_req_psum), .r_addr_psum(r_addr_psum), .r_data_psum(r_data_psum),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [DW-1:0] words    [NL];
  logic [DW-1:0] psum_mem [1024];

  int nw = 0, na = 0, beats = 0, nreq = 0, nacc = 0, nstart = 0;
  int start_cyc = -100, cd_cyc = 0, last_beat_cyc = -100, first_req_cyc = -1;
  int prev_idx = 0;
  int mr_mode = 0;
  bit prev_acc = 1'b0, prev_last = 1'b0, held = 1'b0, ld_on = 1'b0;
  logic [DW-1:0] held_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_done"},   32'(job_done), 0);
    chk({tag, "_sready"}, 32'(s_ready), 0);
    chk({tag, "_wenw"},   32'(write_en_wght), 0);
    chk({tag, "_waddrw"}, 32'(w_addr_wght), 0);
    chk({tag, "_wdataw"}, 32'(w_data_wght), 0);
    chk({tag, "_wena"},   32'(write_en_iact), 0);
    chk({tag, "_waddra"}, 32'(w_addr_iact), 0);
    chk({tag, "_wdataa"}, 32'(w_data_iact), 0);
    chk({tag, "_start"},  32'(start), 0);
    chk({tag, "_rreq"},   32'(read_req_psum), 0);
    chk({tag, "_raddr"},  32'(r_addr_psum), 0);
    chk({tag, "_mvalid"}, 32'(m_valid), 0);
    chk({tag, "_mdata"},  32'(m_data), 0);
    chk({tag, "_mlast"},  32'(m_last), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // GLB psum bank: data for a request seen in cycle t is valid during t+1.
  initial begin
    bit            req_seen;
    logic [AW-1:0] a;
    r_data_psum = '0;
    forever begin
      @(negedge clk);
      req_seen = read_req_psum;
      a        = r_addr_psum;
      @(posedge clk);
      #1;
      r_data_psum = req_seen ? psum_mem[a] : 16'($urandom);
    end
  end

  // Output-side ready pattern.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mr_mode)
        1: m_ready = 1'($urandom_range(0, 1));
        2: begin
          if (first_req_cyc >= 0 && cyc >= first_req_cyc + 4 && cyc < first_req_cyc + 9)
            m_ready = 1'b0;
          else if (first_req_cyc >= 0 && cyc >= first_req_cyc + 9)
            m_ready = cyc[0];
          else
            m_ready = 1'b1;
        end
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Protocol monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    chk("wen_w", 32'(write_en_wght), 32'(prev_acc && prev_idx < NW));
    chk("wen_a", 32'(write_en_iact), 32'(prev_acc && prev_idx >= NW));
    if (write_en_wght) begin
      chk("waddr_w", 32'(w_addr_wght), (WB + nw) % 1024);
      chk("wdata_w", 32'(w_data_wght), 32'(words[nw % NL]));
      nw++;
    end
    if (write_en_iact) begin
      chk("waddr_a", 32'(w_addr_iact), (IB + na) % 1024);
      chk("wdata_a", 32'(w_data_iact), 32'(words[(NW + na) % NL]));
      na++;
    end
    chk("s_ready", 32'(s_ready), 32'(ld_on && beats < NL));
    prev_acc = s_valid && s_ready;
    prev_idx = beats;
    if (prev_acc) begin
      beats++;
      if (beats == NL) last_beat_cyc = cyc;
    end

    if (start) begin
      chk("start_time", cyc, last_beat_cyc + 1);
      nstart++;
      start_cyc = cyc;
    end

    if (read_req_psum) begin
      if (nreq == 0) begin
        first_req_cyc = cyc;
        chk("first_rd", cyc, ((cd_cyc > start_cyc + 1) ? cd_cyc : start_cyc + 1) + 1);
      end
      chk("rd_addr", 32'(r_addr_psum), (PB + nreq) % 1024);
      chk("rd_credit", 32'((nreq - nacc) < 2), 1);
      chk("rd_limit", 32'(nreq < NP), 1);
      nreq++;
    end

    if (held) begin
      chk("hold_valid", 32'(m_valid), 1);
      chk("hold_data", 32'(m_data), 32'(held_data));
    end
    chk("m_last", 32'(m_last), 32'(m_valid && nacc == NP - 1));
    chk("job_done", 32'(job_done), 32'(prev_last));
    prev_last = m_valid && m_ready && m_last;
    if (m_valid && m_ready) begin
      chk("m_data", 32'(m_data), 32'(psum_mem[(PB + nacc) % 1024]));
      nacc++;
    end
    held      = reset && m_valid && !m_ready;
    held_data = m_data;
  end

  // One complete job; vmode: 0 always valid, 1 toggling, 2 random.
  task automatic run_job(input int vmode, input int mmode, input int delay,
                         input bit early, input bit do_rst, input bit det);
    int  idx;
    int  g;
    bit  acc;
    bit  seen;
    for (int i = 0; i < NL; i++) words[i] = det ? 16'(i + 1) : 16'($urandom);
    for (int i = 0; i < 1024; i++) psum_mem[i] = det ? 16'(i + 100) : 16'($urandom);
    nw = 0; na = 0; beats = 0; nreq = 0; nacc = 0; nstart = 0;
    start_cyc = -100; last_beat_cyc = -100; first_req_cyc = -1; ld_on = 1'b0;
    mr_mode = mmode;
    cd_cyc  = cyc;
    compute_done = early;

    cmd_go = 1'b1;
    @(negedge clk);
    chk("go_busy0", 32'(busy), 0);
    @(posedge clk); #1;
    cmd_go = 1'b0;
    ld_on  = 1'b1;
    @(negedge clk);
    chk("go_busy1", 32'(busy), 1);
    chk("go_sready", 32'(s_ready), 1);
    @(posedge clk); #1;

    idx = 0;
    g   = 0;
    while (idx < NL && g < 1000) begin
      case (vmode)
        0:       s_valid = 1'b1;
        1:       s_valid = cyc[0];
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = s_valid ? words[idx] : 16'($urandom);
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      g++;
    end
    s_valid = 1'b0;
    if (idx < NL) chk("load_timeout", 0, 1);

    g = 0;
    while (nstart == 0 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (nstart == 0) chk("start_timeout", 0, 1);

    if (!early) begin
      cmd_go = 1'b1;
      repeat (delay) begin
        @(posedge clk); #1;
      end
      cmd_go       = 1'b0;
      compute_done = 1'b1;
      cd_cyc       = cyc;
    end

    if (do_rst) begin
      g = 0;
      while (nacc < 4 && g < 200) begin
        @(posedge clk); #1;
        g++;
      end
      if (nacc < 4) chk("drain_timeout", 0, 1);
      reset = 1'b0;
      @(posedge clk); #1;
      reset        = 1'b1;
      compute_done = 1'b0;
      @(negedge clk);
      chk_rst_vals("midrst");
      repeat (3) begin
        @(negedge clk);
        chk("post_rst_quiet", 32'({read_req_psum, write_en_wght, write_en_iact, m_valid, busy}), 0);
      end
      @(posedge clk); #1;
      return;
    end

    seen = 1'b0;
    g    = 0;
    while (!seen && g < 500) begin
      @(negedge clk);
      seen = job_done;
      g++;
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
    compute_done = 1'b0;
    @(negedge clk);
    chk("end_busy", 32'(busy), 0);
    chk("end_nw", nw, NW);
    chk("end_na", na, NA);
    chk("end_nreq", nreq, NP);
    chk("end_nacc", nacc, NP);
    chk("end_nstart", nstart, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    reset        = 1'b0;
    cmd_go       = 1'b0;
    s_valid      = 1'b0;
    s_data       = '0;
    compute_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_rst_vals("por");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_job(0, 0, 20, 1'b0, 1'b0, 1'b1);   // basic deterministic job
    run_job(1, 2, 5,  1'b0, 1'b0, 1'b0);   // input bubbles + backpressure
    run_job(2, 1, 0,  1'b1, 1'b0, 1'b0);   // compute_done already high
    run_job(0, 0, 3,  1'b0, 1'b1, 1'b0);   // reset mid-drain
    run_job(2, 0, 7,  1'b0, 1'b0, 1'b0);   // rerun after reset
    for (int j = 0; j < 3; j++)
      run_job(2, 1, $urandom_range(0, 10), 1'($urandom_range(0, 1)), 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
